guard_histogram: RTL and testbench
==================================

# guard_histogram

Stream consumer for the pattern-guard sign classifier: accepts a packet of signed arguments over a valid/ready stream and classifies each one with the guard function (negative → code 0, positive → code 1, zero → code 2). It keeps one count per class. When the packet ends, it presents the three counts and their total on a held output handshake. It sits downstream of argument producers in generated dataflow designs, and is the consuming end of the classifier's code output.

## Interface
- WIDTH, 8, argument width; two's-complement signed
- CNT_W, 16, width of each class counter
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  argument present
- in_ready  out  1  block can accept argument
- in_data  in  WIDTH  signed argument
- in_last  in  1  final argument of packet; qualified by in_valid
- out_valid  out  1  report present
- out_ready  in  1  downstream accepts report
- out_neg  out  CNT_W  count of code-0 (negative) arguments
- out_pos  out  CNT_W  count of code-1 (positive) arguments
- out_zero  out  CNT_W  count of code-2 (zero) arguments
- out_total  out  CNT_W+2  out_neg + out_pos + out_zero, zero-extended sum
- out_sat  out  1  at least one counter saturated during this packet

## Operation
- State machine has two states, ACCUM and REPORT. Reset state is ACCUM.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - Accept = in_valid & in_ready. On accept, the counter selected by the classifier code increments.
  - Counters saturate at 2^CNT_W−1. A saturating increment sets the sticky sat flag.
  - Accept with in_last = 1: the last argument is counted, then next state is REPORT.
- REPORT:
  - in_ready = 0, out_valid = 1.
  - out_* hold registered final counts, stable until the handshake completes.
  - out_valid & out_ready: all counters and sat clear, next state is ACCUM.
- Classification is signed:
  - in_data[WIDTH−1] = 1 → negative.
  - All bits zero → zero.
  - Otherwise → positive.
  - Example: 0x80 is negative, 0x7F is positive.
- Empty packet: not possible. in_last always arrives with an argument, so out_total ≥ 1.
- in_last = 1 while in_valid = 0 is ignored.
- Arguments presented while in REPORT are held off by in_ready = 0. No data is lost or dropped.
- Reset is asynchronous and may occur mid-packet or mid-report. It forces:
  - state ACCUM
  - all counters and sat to 0
  - out_valid = 0, in_ready = 1
  - The partial packet is discarded.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0
  - out_neg = out_pos = out_zero = 0, out_total = 0, out_sat = 0
- in_ready and out_valid are pure functions of state, registered. There is no combinational path from in_valid or out_ready.
- Counter update occurs on the clock edge of the accept cycle.
- Report latency: out_valid rises on the first edge after the edge accepting in_last, i.e. one cycle after the last-argument accept.
- Throughput:
  - One argument per cycle in ACCUM.
  - Report occupies ≥ 1 cycle. With out_ready tied high, REPORT lasts exactly one cycle.
  - Minimum packet-to-packet gap: one bubble cycle on in_ready.
- The first argument of the next packet is accepted on the cycle after the report handshake, and counts from 0.
- out_total is combinational from the registered counters. It is valid whenever out_valid = 1.

## Structure
- Shared package holds:
  - class code constants CLS_NEG = 2'd0, CLS_POS = 2'd1, CLS_ZERO = 2'd2
  - state encoding ST_ACCUM, ST_REPORT
- One sub-module, sign_class: combinational classifier, WIDTH input to 2-bit code, applying the guard order (less-than-zero, then greater-than-zero, else zero). It is instantiated once, on in_data.
- The top holds the FSM, three saturating counters, the sat flag and the total adder.

## Test plan
- Packet {0xFF, 0x00, 0x05, 0x80, 0x00 (last)}, out_ready = 1 → one cycle after last accept, out_valid = 1 with neg = 2, pos = 1, zero = 2, total = 5, sat = 0. out_valid is high for exactly one cycle.
- Single-element packet {0x7F (last)}, then out_ready held 0 for 4 cycles → report neg = 0, pos = 1, zero = 0, total = 1.
  - Report stable for 5 cycles. in_ready = 0 throughout, with in_valid held high on the next packet's first argument.
  - That argument is accepted on the cycle after the handshake.
- Back-to-back packets {0x01, 0x02 (last)} and {0xFE (last)}, with in_valid continuous and out_ready = 1:
  - Reports are pos = 2 then neg = 1, total = 1.
  - Exactly one in_ready = 0 bubble between them.
- CNT_W = 4, 20 arguments of 0x10 then 0x00 (last) → pos = 15 (saturated), zero = 1, total = 16, sat = 1.
  - The next packet reports sat = 0.
- Reset asserted asynchronously after 3 arguments of a packet, and again during REPORT with out_ready = 0:
  - Outputs return immediately to the reset values.
  - Following packet {0x00 (last)} reports zero = 1, total = 1.
- in_last pulsed with in_valid = 0 between arguments → no report, and counting continues.

Source files
------------

// File: rtl/guard_histogram_pkg.sv
// Shared definitions for the guard histogram consumer: the classifier's
// sign codes and the two-state encoding of the accumulate/report FSM.
package guard_histogram_pkg;

    // Codes produced by the sign classifier, one per histogram bin
    localparam logic [1:0] CLS_NEG  = 2'd0;
    localparam logic [1:0] CLS_POS  = 2'd1;
    localparam logic [1:0] CLS_ZERO = 2'd2;

    // Accumulating arguments of a packet, or holding the finished report
    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

endpackage

// File: rtl/guard_histogram_sign_class.sv
// Combinational sign classifier. The guards are evaluated in order:
// less than zero, then greater than zero, otherwise zero.
module sign_class
    import guard_histogram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic [1:0]       code
);

    // The sign bit alone decides "less than zero" for two's-complement data,
    // so 0x80 lands in the negative bin and 0x7F in the positive bin.
    always_comb begin
        code = CLS_ZERO;
        if (data[WIDTH-1]) begin
            code = CLS_NEG;
        end else if (data != '0) begin
            code = CLS_POS;
        end
    end

endmodule

// File: rtl/guard_histogram.sv
// Packet histogram of argument signs. Arguments stream in over a
// valid/ready port and are binned by sign; when the last argument of a
// packet has been counted the three bin counts, their total and a sticky
// saturation flag are offered on a held output handshake.
module guard_histogram
    import guard_histogram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_neg,
    output logic [CNT_W-1:0]   out_pos,
    output logic [CNT_W-1:0]   out_zero,
    output logic [CNT_W+1:0]   out_total,
    output logic               out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           next_state;
    logic [1:0]       cls_code;
    logic             accept;
    logic             report_done;
    logic             hit_neg;
    logic             hit_pos;
    logic             hit_zero;
    logic             full_neg;
    logic             full_pos;
    logic             full_zero;
    logic             sat_hit;
    logic [CNT_W-1:0] cnt_neg;
    logic [CNT_W-1:0] cnt_pos;
    logic [CNT_W-1:0] cnt_zero;
    logic             sat_flag;

    sign_class #(
        .WIDTH (WIDTH)
    ) u_sign_class (
        .data (in_data),
        .code (cls_code)
    );

    assign accept      = in_valid & in_ready;
    assign report_done = out_valid & out_ready;

    assign hit_neg  = accept && (cls_code == CLS_NEG);
    assign hit_pos  = accept && (cls_code == CLS_POS);
    assign hit_zero = accept && (cls_code == CLS_ZERO);

    assign full_neg  = (cnt_neg  == CNT_MAX);
    assign full_pos  = (cnt_pos  == CNT_MAX);
    assign full_zero = (cnt_zero == CNT_MAX);

    // An increment that would wrap is swallowed and remembered instead
    assign sat_hit = (hit_neg && full_neg) || (hit_pos && full_pos) || (hit_zero && full_zero);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Leave ACCUM once the last argument is taken; leave REPORT on handshake
    always_comb begin
        next_state = state;
        case (state)
            ST_ACCUM: begin
                if (accept && in_last) begin
                    next_state = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (out_ready) begin
                    next_state = ST_ACCUM;
                end
            end
            default: next_state = ST_ACCUM;
        endcase
    end

    // Handshake strobes depend only on the registered state, never on the
    // incoming valid/ready, so neither port sees a combinational path
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACCUM:  in_ready  = 1'b1;
            ST_REPORT: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Negative-bin counter, saturating, cleared when the report is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_neg <= '0;
        end else if (report_done) begin
            cnt_neg <= '0;
        end else if (hit_neg && !full_neg) begin
            cnt_neg <= cnt_neg + 1'b1;
        end
    end

    // Positive-bin counter, saturating, cleared when the report is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_pos <= '0;
        end else if (report_done) begin
            cnt_pos <= '0;
        end else if (hit_pos && !full_pos) begin
            cnt_pos <= cnt_pos + 1'b1;
        end
    end

    // Zero-bin counter, saturating, cleared when the report is taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_zero <= '0;
        end else if (report_done) begin
            cnt_zero <= '0;
        end else if (hit_zero && !full_zero) begin
            cnt_zero <= cnt_zero + 1'b1;
        end
    end

    // Sticky saturation flag covering the whole packet
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (report_done) begin
            sat_flag <= 1'b0;
        end else if (sat_hit) begin
            sat_flag <= 1'b1;
        end
    end

    assign out_neg  = cnt_neg;
    assign out_pos  = cnt_pos;
    assign out_zero = cnt_zero;
    assign out_sat  = sat_flag;

    // Two guard bits keep the sum of three full counters from wrapping
    assign out_total = {2'b00, cnt_neg} + {2'b00, cnt_pos} + {2'b00, cnt_zero};

endmodule

// File: tb/tb_guard_histogram.sv
// Self-checking bench for guard_histogram: directed scenarios followed by
// randomized packets, all compared against a packet-level sign histogram.
module tb_guard_histogram;

    logic        clock;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_neg;
    logic [15:0] out_pos;
    logic [15:0] out_zero;
    logic [17:0] out_total;
    logic        out_sat;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic        s_in_last;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [3:0]  s_out_neg;
    logic [3:0]  s_out_pos;
    logic [3:0]  s_out_zero;
    logic [5:0]  s_out_total;
    logic        s_out_sat;

    int total_checks = 0;
    int bad_checks   = 0;
    int last_wait    = 0;
    logic [7:0] pkt_q[$];

    int  exp_n;
    int  exp_p;
    int  exp_z;
    int  exp_t;
    logic exp_s;

    guard_histogram #(.WIDTH(8), .CNT_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_neg   (out_neg),
        .out_pos   (out_pos),
        .out_zero  (out_zero),
        .out_total (out_total),
        .out_sat   (out_sat)
    );

    guard_histogram #(.WIDTH(8), .CNT_W(4)) dut_small (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_last   (s_in_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_neg   (s_out_neg),
        .out_pos   (s_out_pos),
        .out_zero  (s_out_zero),
        .out_total (s_out_total),
        .out_sat   (s_out_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something stalls beyond every bounded wait
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) else begin
            bad_checks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference histogram of pkt_q: raw sign counts, clamped to cmax
    task automatic model_packet(input int cmax, output int n, output int p, output int z,
                                output int t, output logic s);
        int rn;
        int rp;
        int rz;
        int v;
        rn = 0;
        rp = 0;
        rz = 0;
        foreach (pkt_q[i]) begin
            v = (pkt_q[i] >= 8'd128) ? int'(pkt_q[i]) - 256 : int'(pkt_q[i]);
            if (v < 0) rn++;
            else if (v > 0) rp++;
            else rz++;
        end
        s = (rn > cmax) || (rp > cmax) || (rz > cmax);
        n = (rn > cmax) ? cmax : rn;
        p = (rp > cmax) ? cmax : rp;
        z = (rz > cmax) ? cmax : rz;
        t = n + p + z;
    endtask

    task automatic check_report(input string tag);
        check_output({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_output({tag, "_ready"}, 32'(in_ready),  32'd0);
        check_output({tag, "_neg"},   32'(out_neg),   32'(exp_n));
        check_output({tag, "_pos"},   32'(out_pos),   32'(exp_p));
        check_output({tag, "_zero"},  32'(out_zero),  32'(exp_z));
        check_output({tag, "_total"}, 32'(out_total), 32'(exp_t));
        check_output({tag, "_sat"},   32'(out_sat),   32'(exp_s));
    endtask

    // Offer one argument (after an optional idle gap) and return once taken
    task automatic apply_stimulus(input logic [7:0] data, input logic last, input int gap);
        int waited;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_last = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 50) check_output("accept_timeout", 32'(in_ready), 32'd1);
        last_wait = waited;
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_packet(input int gap_max);
        for (int i = 0; i < pkt_q.size(); i++) begin
            apply_stimulus(pkt_q[i], i == pkt_q.size() - 1, $urandom_range(0, gap_max));
        end
    endtask

    task automatic take_report();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = 8'h00;
        s_in_last   = 1'b0;
        s_out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_output("rst_in_ready",  32'(in_ready),  32'd1);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_total",     32'(out_total), 32'd0);
        check_output("rst_sat",       32'(out_sat),   32'd0);

        // Mixed packet with out_ready high: report lasts one cycle
        $display("[TB] mixed packet");
        out_ready = 1'b1;
        pkt_q = '{8'hFF, 8'h00, 8'h05, 8'h80, 8'h00};
        send_packet(0);
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_report("mixed");
        @(negedge clock);
        check_output("mixed_one_cycle", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Single-element packet, report held while downstream stalls
        $display("[TB] held report");
        pkt_q = '{8'h7F};
        send_packet(0);
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) out_ready = 1'b1;
            check_report("held");
            @(negedge clock);
        end
        out_ready = 1'b0;
        check_output("held_after_valid", 32'(out_valid), 32'd0);
        check_output("held_after_ready", 32'(in_ready),  32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        apply_stimulus(8'h00, 1'b1, 0);
        pkt_q = '{8'h01, 8'h00};
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_report("held_next");
        take_report();

        // Back-to-back packets with continuous valid
        $display("[TB] back to back");
        out_ready = 1'b1;
        apply_stimulus(8'h01, 1'b0, 0);
        apply_stimulus(8'h02, 1'b1, 0);
        pkt_q = '{8'h01, 8'h02};
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_report("b2b_first");
        apply_stimulus(8'hFE, 1'b1, 0);
        check_output("b2b_bubble", 32'(last_wait), 32'd1);
        pkt_q = '{8'hFE};
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_report("b2b_second");
        @(negedge clock);
        out_ready = 1'b0;

        // Saturation on the narrow-counter instance
        $display("[TB] saturation");
        pkt_q = {};
        for (int k = 0; k < 21; k++) begin
            s_in_valid = 1'b1;
            s_in_data  = (k < 20) ? 8'h10 : 8'h00;
            s_in_last  = (k == 20);
            pkt_q.push_back(s_in_data);
            @(negedge clock);
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        model_packet(15, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_output("sat_valid", 32'(s_out_valid), 32'd1);
        check_output("sat_neg",   32'(s_out_neg),   32'(exp_n));
        check_output("sat_pos",   32'(s_out_pos),   32'(exp_p));
        check_output("sat_zero",  32'(s_out_zero),  32'(exp_z));
        check_output("sat_total", 32'(s_out_total), 32'(exp_t));
        check_output("sat_flag",  32'(s_out_sat),   32'(exp_s));
        s_out_ready = 1'b1;
        @(negedge clock);
        s_in_valid = 1'b1;
        s_in_data  = 8'h01;
        s_in_last  = 1'b1;
        @(negedge clock);
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        check_output("sat_next_valid", 32'(s_out_valid), 32'd1);
        check_output("sat_next_pos",   32'(s_out_pos),   32'd1);
        check_output("sat_next_flag",  32'(s_out_sat),   32'd0);
        @(negedge clock);
        s_out_ready = 1'b0;

        // Asynchronous reset mid-packet and mid-report
        $display("[TB] async reset");
        apply_stimulus(8'h81, 1'b0, 0);
        apply_stimulus(8'h05, 1'b0, 0);
        apply_stimulus(8'h00, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        check_output("arst_pkt_ready", 32'(in_ready),  32'd1);
        check_output("arst_pkt_valid", 32'(out_valid), 32'd0);
        check_output("arst_pkt_neg",   32'(out_neg),   32'd0);
        check_output("arst_pkt_pos",   32'(out_pos),   32'd0);
        check_output("arst_pkt_zero",  32'(out_zero),  32'd0);
        check_output("arst_pkt_total", 32'(out_total), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pkt_q = '{8'h05, 8'h80};
        send_packet(0);
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_report("arst_pre");
        #2 reset = 1'b1;
        #1;
        check_output("arst_rep_ready", 32'(in_ready),  32'd1);
        check_output("arst_rep_valid", 32'(out_valid), 32'd0);
        check_output("arst_rep_total", 32'(out_total), 32'd0);
        check_output("arst_rep_sat",   32'(out_sat),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        pkt_q = '{8'h00};
        send_packet(0);
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_report("arst_after");
        take_report();

        // Stray in_last without in_valid is ignored
        $display("[TB] stray last");
        apply_stimulus(8'h05, 1'b0, 0);
        in_last = 1'b1;
        @(negedge clock);
        in_last = 1'b0;
        check_output("stray_valid", 32'(out_valid), 32'd0);
        check_output("stray_ready", 32'(in_ready),  32'd1);
        apply_stimulus(8'hF0, 1'b1, 0);
        pkt_q = '{8'h05, 8'hF0};
        model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
        check_report("stray");
        take_report();

        // Randomized packets with idle gaps and downstream stalls
        $display("[TB] random packets");
        for (int r = 0; r < 30; r++) begin
            int len;
            int hold;
            len = $urandom_range(1, 8);
            pkt_q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) pkt_q.push_back(8'h00);
                else pkt_q.push_back(8'($urandom));
            end
            send_packet(2);
            model_packet(65535, exp_n, exp_p, exp_z, exp_t, exp_s);
            check_report("rand");
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clock);
                check_output("rand_hold_valid", 32'(out_valid), 32'd1);
                check_output("rand_hold_total", 32'(out_total), 32'(exp_t));
            end
            take_report();
            check_output("rand_released", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
